// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: round-robin two-master to one-slave Avalon-MM arbiter, grant held for a whole transfer.
// Define ARB_TIMEOUT_EN to add a stall watchdog that forces completion after TIMEOUT_CYCLES stalled cycles.
module avalon_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d;
    logic last_q, last_d;
    logic req0, req1, own_req, done, expired, sel1, act;
    logic [DATA_W-1:0] rdata;
    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    assign expired = state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES);
    always_comb begin
        cnt_d = state_q == IDLE ? '0 : cnt_q + CW'(s_waitrequest);
        err_d = err_q | (expired & own_req);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign timeout_err = err_q;
    assign rdata = expired ? DATA_W'(32'hDEADBEEF) : s_readdata;
`else
    assign expired = TIMEOUT_CYCLES < 0;
    assign timeout_err = 1'b0;
    assign rdata = s_readdata;
`endif
    always_comb begin
        own_req = state_q == GNT0 ? req0 : state_q == GNT1 ? req1 : 1'b0;
        done = own_req & (~s_waitrequest | expired);
        state_d = state_q;
        last_d = last_q;
        if (state_q == IDLE)
            state_d = req0 & req1 ? (last_q ? GNT0 : GNT1) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
        else if (!own_req || done) begin
            state_d = IDLE;
            last_d = done ? state_q == GNT1 : last_q;
        end
    end
    // Slave side mirrors the owner combinationally; the watchdog cycle suppresses the command.
    always_comb begin
        sel1 = state_q == GNT1;
        act = state_q != IDLE;
        s_address = act ? (sel1 ? m1_address : m0_address) : '0;
        s_writedata = act ? (sel1 ? m1_writedata : m0_writedata) : '0;
        s_byteenable = act ? (sel1 ? m1_byteenable : m0_byteenable) : '0;
        s_write = act & ~expired & (sel1 ? m1_write : m0_write);
        s_read = act & ~expired & (sel1 ? m1_read & ~m1_write : m0_read & ~m0_write);
        m0_waitrequest = state_q == GNT0 ? s_waitrequest & ~expired : req0;
        m1_waitrequest = state_q == GNT1 ? s_waitrequest & ~expired : req1;
        m0_readdata = state_q == GNT0 ? rdata : '0;
        m1_readdata = state_q == GNT1 ? rdata : '0;
        grant = {state_q == GNT1, state_q == GNT0};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb_avalon_mem_arbiter: cycle-table and hand-written sequences for the two-master Avalon arbiter.
module tb_avalon_mem_arbiter;
    localparam logic [31:0] A0 = 32'hBFC00000, A1 = 32'h00001000, WD0 = 32'h11111111, WD1 = 32'hCAFEBABE;
    localparam logic [3:0] BE0 = 4'hF, BE1 = 4'h3;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] m0_address = A0, m1_address = A1, m0_writedata = WD0, m1_writedata = WD1;
    logic [3:0] m0_byteenable = BE0, m1_byteenable = BE1;
    logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0, s_waitrequest = 0;
    logic [31:0] s_readdata = '0;
    logic m0_waitrequest, m1_waitrequest, s_read, s_write, timeout_err;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic [3:0] s_byteenable;
    logic [1:0] grant;
    int checks = 0, errors = 0;

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r0, w0, r1, w1, sw;
        logic [31:0] sd;
        logic [1:0] g;
        logic wt0, wt1, sr, swr;
        logic [31:0] rd0, rd1;
    } vec_t;
    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic r0, logic w0, logic r1, logic w1, logic sw, logic [31:0] sd,
                                logic [1:0] g, logic wt0, logic wt1, logic sr, logic swr,
                                logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.sw = sw; v.sd = sd;
        v.g = g; v.wt0 = wt0; v.wt1 = wt1; v.sr = sr; v.swr = swr; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic r1, input logic w1,
                         input logic sw, input logic [31:0] sd);
        m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1;
        s_waitrequest = sw; s_readdata = sd;
    endtask

    task automatic check_vec(input int idx);
        vec_t e;
        logic [31:0] ea, ewd;
        logic [3:0] ebe;
        string tag;
        e = exp_q.pop_front();
        ea = e.g == 2'b01 ? A0 : e.g == 2'b10 ? A1 : '0;
        ewd = e.g == 2'b01 ? WD0 : e.g == 2'b10 ? WD1 : '0;
        ebe = e.g == 2'b01 ? BE0 : e.g == 2'b10 ? BE1 : '0;
        tag = $sformatf("v%0d", idx);
        chk({tag, " grant"}, 32'(grant), 32'(e.g));
        chk({tag, " m0_waitrequest"}, 32'(m0_waitrequest), 32'(e.wt0));
        chk({tag, " m1_waitrequest"}, 32'(m1_waitrequest), 32'(e.wt1));
        chk({tag, " s_read"}, 32'(s_read), 32'(e.sr));
        chk({tag, " s_write"}, 32'(s_write), 32'(e.swr));
        chk({tag, " m0_readdata"}, m0_readdata, e.rd0);
        chk({tag, " m1_readdata"}, m1_readdata, e.rd1);
        chk({tag, " s_address"}, s_address, ea);
        chk({tag, " s_writedata"}, s_writedata, ewd);
        chk({tag, " s_byteenable"}, 32'(s_byteenable), 32'(ebe));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset s_read/s_write", 32'({s_read, s_write}), 32'h0);
        chk("reset s_address", s_address, 32'h0);
        chk("reset s_writedata", s_writedata, 32'h0);
        chk("reset s_byteenable", 32'(s_byteenable), 32'h0);
        chk("reset timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {r0,w0,r1,w1,sw,sd, grant,wt0,wt1,s_read,s_write,rd0,rd1}
        // simultaneous requests after reset: m0 first, m1 after one idle cycle, then m0 again
        vecs.push_back(mk(1,0,0,1,0,0,            2'b00,1,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,32'h11,       2'b01,0,1,1,0,32'h11,0));
        vecs.push_back(mk(0,0,0,1,0,0,            2'b00,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,32'h22,       2'b10,0,0,0,1,0,32'h22));
        vecs.push_back(mk(1,0,1,0,0,0,            2'b00,1,1,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,32'h33,       2'b01,0,1,1,0,32'h33,0));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));
        // single m0 read with two slave stall cycles
        vecs.push_back(mk(1,0,0,0,1,0,            2'b00,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,            2'b01,1,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,            2'b01,1,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,32'h24020005, 2'b01,0,0,1,0,32'h24020005,0));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));
        // m1 write while m0 idle
        vecs.push_back(mk(0,0,0,1,1,0,            2'b00,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,            2'b10,0,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,0,32'h44,       2'b10,0,0,0,1,0,32'h44));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));
        // m0 withdraws while granted; next contention still goes to m0
        vecs.push_back(mk(1,0,0,0,1,0,            2'b00,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,            2'b01,1,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,32'h99,       2'b01,1,0,0,0,32'h99,0));
        vecs.push_back(mk(1,0,1,0,0,0,            2'b00,1,1,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,32'h55,       2'b01,0,1,1,0,32'h55,0));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));
        // read+write together is a write
        vecs.push_back(mk(0,0,1,1,0,0,            2'b00,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,32'h66,       2'b10,0,0,0,1,0,32'h66));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));
        // m0 write
        vecs.push_back(mk(0,1,0,0,0,0,            2'b00,1,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,32'h77,       2'b01,0,0,0,1,32'h77,0));
        vecs.push_back(mk(0,0,0,0,0,0,            2'b00,0,0,0,0,0,0));

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1, vecs[i].sw, vecs[i].sd);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            check_vec(i);
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of a stalled m1 write
        drive(0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        chk("midgnt1 grant", 32'(grant), 32'h2);
        chk("midgnt1 s_write", 32'(s_write), 32'h1);
        reset = 1'b1;
        #1;
        chk("async reset grant", 32'(grant), 32'h0);
        chk("async reset s_write", 32'(s_write), 32'h0);
        chk("async reset s_address", s_address, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 1, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("post-reset contention grant", 32'(grant), 32'h1);
        s_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

`ifdef ARB_TIMEOUT_EN
        do_reset();
        drive(1, 0, 0, 0, 1, 32'h12345678);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d m0_waitrequest", i), 32'(m0_waitrequest), 32'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("timeout m0_waitrequest", 32'(m0_waitrequest), 32'h0);
        chk("timeout m0_readdata", m0_readdata, 32'hDEADBEEF);
        chk("timeout s_read", 32'(s_read), 32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("timeout_err sticky", 32'(timeout_err), 32'h1);
            chk("timeout grant idle", 32'(grant), 32'h0);
        end
`else
        do_reset();
        drive(1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 0) begin
                chk("long stall grant", 32'(grant), 32'h1);
                chk("long stall m0_waitrequest", 32'(m0_waitrequest), 32'h1);
                chk("long stall timeout_err", 32'(timeout_err), 32'h0);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
`endif
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left unchecked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter placed between mips_cpu_bus and the shared memory.
- m0 is the CPU bus port; m1 is a secondary master (program loader or DMA).
- Arbitration is round-robin. A grant is locked for the full transfer, up to and including the cycle in which the slave drops waitrequest.
- Read data has zero latency: readdata is valid in the completion cycle, matching the CPU's bus timing.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit in stalled cycles (used only when ARB_TIMEOUT_EN is defined).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  CPU address
- m0_read / m0_write  in  1 each  CPU read / write request
- m0_writedata  in  DATA_W  CPU write data
- m0_byteenable  in  DATA_W/8  CPU byte lanes
- m0_waitrequest  out  1  stall to CPU
- m0_readdata  out  DATA_W  read data to CPU
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest, m1_readdata: same as m0_*, for master 1
- s_address  out  ADDR_W  to memory
- s_read / s_write  out  1 each  to memory
- s_writedata  out  DATA_W  to memory
- s_byteenable  out  DATA_W/8  to memory
- s_waitrequest  in  1  from memory
- s_readdata  in  DATA_W  from memory
- grant  out  2  one-hot current owner ({m1,m0}); 00 when idle
- timeout_err  out  1  sticky watchdog flag (tied 0 when the feature is compiled out)

Behaviour:
- State machine: IDLE, GNT0, GNT1. A 1-bit last_owner register drives round-robin.
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE; last_owner goes to 1, so m0 wins the first contention.
  - grant=00, s_read=s_write=0, s_address/s_writedata/s_byteenable=0, timeout_err=0.
  - Any in-flight transfer is abandoned.
- A master is requesting when its read or write is high. Read and write asserted together is illegal and treated as write.
- IDLE:
  - Slave outputs are 0.
  - Any requesting master sees waitrequest=1; a non-requesting master sees 0.
  - At the clock edge:
    - Only one master requesting: that master is granted.
    - Both requesting: grant goes to the master that is not last_owner.
    - Neither requesting: stay in IDLE.
  - Arbitration latency is 1 cycle: a grant is never issued in the same cycle the request first appears.
- GNTx:
  - s_* outputs mirror master x combinationally.
  - mx_waitrequest = s_waitrequest.
  - mx_readdata = s_readdata.
  - The other master sees waitrequest=1 if requesting, otherwise 0; its readdata is 0.
- Completion: at an edge in GNTx where master x is requesting and s_waitrequest=0.
  - last_owner is set to x and the state returns to IDLE.
  - There is always one dead cycle between transfers, so master x's next request is re-arbitrated fairly.
- Request withdrawn while granted (an Avalon violation): return to IDLE, last_owner unchanged, no error.
- Unbounded stall: with the feature compiled out, a grant is held for as long as s_waitrequest stays high.
- A master must hold address, writedata and byteenable stable while its waitrequest is high. The arbiter does not register them.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to GNTx and increments each GNTx cycle with s_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES, the arbiter:
    - asserts mx_waitrequest=0 for one cycle with mx_readdata=32'hDEADBEEF, forcing completion;
    - deasserts s_read/s_write in that cycle;
    - sets timeout_err (sticky until reset);
    - goes to IDLE with last_owner=x.
- Not defined: no counter is present, timeout_err is tied 0, and stalls are unbounded.

Test Plan:
- Single m0 read, addr 0xBFC00000, slave waitrequest high 2 cycles, readdata 0x24020005 -> grant=01 one cycle after request; m0_waitrequest high 3 cycles total; m0_readdata=0x24020005 in the completion cycle; then grant=00.
- m0 and m1 request in the same cycle after reset -> m0 served first. m1 is granted on the edge after m0 completes plus one IDLE cycle. A third simultaneous request from both goes to m0 (round-robin).
- m1 write 0xCAFEBABE, byteenable 0011, addr 0x1000 while m0 idle -> s_write=1, s_writedata=0xCAFEBABE, s_byteenable=0011 for the whole grant; m0 sees waitrequest=0 and readdata=0.
- Reset asserted mid-GNT1 with s_waitrequest high -> grant=00 and s_write=0 immediately (asynchronously). After release, simultaneous requests go to m0.
- m0 drops read while granted -> IDLE next edge; the next contention is still won by m0 (last_owner unchanged).
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, s_waitrequest stuck high -> after 4 stalled cycles, m0_waitrequest=0 and m0_readdata=0xDEADBEEF for 1 cycle; timeout_err=1 and held.
